fifo_uart_tx: RTL

- Downstream consumer of the synchronous FIFO: pops bytes whenever the FIFO is non-empty and enabled, and serialises each one as an 8N1 asynchronous frame on a single line.
- Drives the FIFO read port directly (rd_en in; rdata, empty and rd_error out of the FIFO).
- Sits between the byte buffer and the chip's serial TX pin.

---
 rtl/fifo_uart_tx_pkg.sv | 18 +
 rtl/fifo_uart_tx_if.sv | 24 ++
 rtl/fifo_uart_tx_bit_timer.sv | 28 ++
 rtl/fifo_uart_tx.sv | 113 +++++++++++
 4 files changed

// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-fed 8N1 UART transmitter: FSM state
// encoding and serial line levels.
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read-port bundle between the synchronous FIFO (slave) and its
// consumer, the UART transmitter (master).
interface fifo_uart_tx_if #(
    parameter int WIDTH = 8
);
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_rdata;
    logic             fifo_rd_error;
    logic             fifo_rd_en;

    modport master (
        output fifo_rd_en,
        input  fifo_empty,
        input  fifo_rdata,
        input  fifo_rd_error
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_empty,
        output fifo_rdata,
        output fifo_rd_error
    );
endinterface

// File: rtl/fifo_uart_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while running and flags the
// last cycle of each bit period.
module tx_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic run_i,
    output logic bit_tick_o
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_i || !run_i) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bit_tick_o = run_i && (r_cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-draining 8N1 serial transmitter: pops one byte per frame from the
// FIFO read port and shifts it out LSB first between start and stop bits.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    fifo_uart_tx_if.master        fifo,
    output logic                  tx_o,
    output logic                  busy_o,
    output logic                  byte_done_o,
    output logic                  err_o
);
    localparam int BIT_W = $clog2(WIDTH + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

    state_t             r_state, w_state_next;
    logic [WIDTH-1:0]   r_shift, w_shift_next;
    logic [BIT_W-1:0]   r_bit_cnt, w_bit_cnt_next;
    logic               r_tx, w_tx_next;
    logic               r_rd_en, w_rd_en_next;
    logic               r_busy, w_busy_next;
    logic               r_byte_done, w_byte_done_next;
    logic               r_err, w_err_next;
    logic               w_run;
    logic               w_bit_tick;

    assign w_run = (r_state == START) || (r_state == DATA) || (r_state == STOP);

    tx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .run_i      (w_run),
        .bit_tick_o (w_bit_tick)
    );

    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_cnt_next = r_bit_cnt;
        case (r_state)
            IDLE:  if (enable_i && !fifo.fifo_empty) w_state_next = FETCH;
            FETCH: w_state_next = LOAD;
            LOAD: begin
                w_shift_next = fifo.fifo_rdata;
                w_state_next = fifo.fifo_rd_error ? IDLE : START;
            end
            START: if (w_bit_tick) w_state_next = DATA;
            DATA: begin
                if (w_bit_tick) begin
                    w_shift_next = r_shift >> 1;
                    if (r_bit_cnt == LAST_BIT) begin
                        w_bit_cnt_next = '0;
                        w_state_next   = STOP;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 1'b1;
                    end
                end
            end
            STOP:  if (w_bit_tick) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase

        // Outputs are decoded from the next state so each lands in a flop
        // aligned with the state it belongs to.
        w_tx_next = LINE_IDLE;
        case (w_state_next)
            START:   w_tx_next = START_BIT;
            DATA:    w_tx_next = w_shift_next[0];
            STOP:    w_tx_next = STOP_BIT;
            default: w_tx_next = LINE_IDLE;
        endcase
        w_rd_en_next     = (w_state_next == FETCH);
        w_busy_next      = (w_state_next != IDLE);
        w_byte_done_next = (r_state == STOP) && w_bit_tick;
        w_err_next       = (r_state == LOAD) && fifo.fifo_rd_error;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_tx        <= LINE_IDLE;
            r_rd_en     <= 1'b0;
            r_busy      <= 1'b0;
            r_byte_done <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_shift     <= w_shift_next;
            r_bit_cnt   <= w_bit_cnt_next;
            r_tx        <= w_tx_next;
            r_rd_en     <= w_rd_en_next;
            r_busy      <= w_busy_next;
            r_byte_done <= w_byte_done_next;
            r_err       <= w_err_next;
        end
    end

    assign fifo.fifo_rd_en = r_rd_en;
    assign tx_o            = r_tx;
    assign busy_o          = r_busy;
    assign byte_done_o     = r_byte_done;
    assign err_o           = r_err;

endmodule
